// File: rtl/bicubic_axis_tx.sv
// bicubic_axis_tx: output-side AXI4-Stream transmitter for the bicubic upscaler.
// Pixels from the interpolation core are tagged with sof/eol/eof when they are
// accepted and held in a two-entry skid buffer: an output register (OR) and a
// skid register (SK). s_ready comes straight from a flop, so there is no
// combinational path from m_axis_tready back to the core.
module bicubic_axis_tx #(
  parameter int unsigned DW    = 24,
  parameter int unsigned OUT_W = 3840,
  parameter int unsigned OUT_H = 2160,
  parameter int unsigned CW    = 12,
  parameter int unsigned RW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tuser,
  output logic          m_axis_tlast,
  output logic          frame_done
);

  // An entry is packed as {eof, eol, sof, data}.
  localparam int unsigned EW = DW + 3;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [EW-1:0] or_q, or_d;
  logic [EW-1:0] sk_q, sk_d;
  logic          or_vld_q, or_vld_d;
  logic          sk_vld_q, sk_vld_d;
  logic          s_ready_q, s_ready_d;
  logic          frame_done_q, frame_done_d;

  logic          in_hs;
  logic          out_hs;
  logic          tag_sof;
  logic          tag_eol;
  logic          tag_eof;
  logic [EW-1:0] new_ent;

  // Handshakes and the position tags of the pixel being accepted this cycle.
  always_comb begin
    in_hs   = s_valid & s_ready_q;
    out_hs  = or_vld_q & m_axis_tready;
    tag_sof = (col_q == '0) && (row_q == '0);
    tag_eol = (col_q == CW'(OUT_W - 1));
    tag_eof = tag_eol && (row_q == RW'(OUT_H - 1));
    new_ent = {tag_eof, tag_eol, tag_sof, s_data};
  end

  // Column/row counters advance on every accepted pixel; frames run back-to-back.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_hs) begin
      if (tag_eol) begin
        col_d = '0;
        if (row_q == RW'(OUT_H - 1)) row_d = '0;
        else                         row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Skid buffer: drain first (SK->OR or OR empties), then place the new pixel.
  // A new pixel only lands in OR when OR is free this cycle and SK holds nothing
  // older, which keeps the stream in order.
  always_comb begin
    or_d     = or_q;
    sk_d     = sk_q;
    or_vld_d = or_vld_q;
    sk_vld_d = sk_vld_q;
    if (out_hs) begin
      if (sk_vld_q) begin
        or_d     = sk_q;
        sk_vld_d = 1'b0;
      end else begin
        or_vld_d = 1'b0;
      end
    end
    if (in_hs) begin
      if ((!or_vld_q || out_hs) && !sk_vld_q) begin
        or_d     = new_ent;
        or_vld_d = 1'b1;
      end else begin
        sk_d     = new_ent;
        sk_vld_d = 1'b1;
      end
    end
    s_ready_d    = ~sk_vld_d;
    frame_done_d = out_hs & or_q[DW+2];
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      or_q         <= '0;
      sk_q         <= '0;
      or_vld_q     <= 1'b0;
      sk_vld_q     <= 1'b0;
      s_ready_q    <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      or_q         <= or_d;
      sk_q         <= sk_d;
      or_vld_q     <= or_vld_d;
      sk_vld_q     <= sk_vld_d;
      s_ready_q    <= s_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign m_axis_tvalid = or_vld_q;
  assign m_axis_tdata  = or_q[DW-1:0];
  assign m_axis_tuser  = or_q[DW];
  assign m_axis_tlast  = or_q[DW+1];
  assign frame_done    = frame_done_q;

endmodule

// File: doc/bicubic_axis_tx.md
# bicubic_axis_tx

Output-side AXI4-Stream transmitter for the bicubic upscaler. It accepts upscaled pixels from the interpolation core over a simple valid/ready port and emits them as an AXI4-Stream video stream with start-of-frame (tuser) and end-of-line (tlast) tags. The tags come from internal column and row counters. A two-entry skid buffer keeps the input-side ready registered, so no combinational path runs from m_axis_tready to s_ready.

## Interface
- DW, 24: pixel width in bits (RGB888).
- OUT_W, 3840: output frame width in pixels, ≥ 2.
- OUT_H, 2160: output frame height in lines, ≥ 1.
- CW, 12: column counter width; must satisfy 2^CW ≥ OUT_W.
- RW, 12: row counter width; must satisfy 2^RW ≥ OUT_H.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  core has a pixel on s_data.
- s_ready  output  1  block can accept a pixel; driven directly from a register.
- s_data  input  DW  upscaled pixel from core.
- m_axis_tvalid  output  1  stream data valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tdata  output  DW  pixel.
- m_axis_tuser  output  1  high on first pixel of frame (row 0, col 0).
- m_axis_tlast  output  1  high on last pixel of each line (col OUT_W-1).
- frame_done  output  1  one-cycle pulse after last pixel of frame is transferred.

## Operation
- Input handshake: s_valid & s_ready at a rising edge.
- Output handshake: m_axis_tvalid & m_axis_tready at a rising edge.
- Tagging happens at input acceptance:
  - sof = (col==0 && row==0).
  - eol = (col==OUT_W-1).
  - eof = eol && (row==OUT_H-1).
  - Tags travel with data as {eof, eol, sof, data}.
- Counters advance on each input handshake:
  - col increments; at OUT_W-1 it wraps to 0 and row increments.
  - row wraps from OUT_H-1 to 0. Frames repeat back-to-back with no gap state.
- Storage is an output register (OR) plus a skid register (SK), each with a valid bit.
  - On an accepted input, if OR is empty or OR is handshaking this cycle, and SK is empty: data loads into OR.
  - Otherwise data loads into SK.
  - On an output handshake with SK valid: SK moves into OR and SK empties.
  - On an output handshake with SK empty and no input: OR empties.
- s_ready next = ~(SK valid next). Any condition leaving SK full deasserts s_ready on the following cycle.
- An input cannot arrive while SK is full, because s_ready is low; this needs no handling.
- m_axis_tdata, m_axis_tuser and m_axis_tlast hold stable while tvalid & ~tready. This is AXI-stream compliant.
- frame_done is registered. It is high for exactly one cycle, the cycle after the output handshake of an entry whose eof tag is set.

## Timing
- Reset values:
  - s_ready=1, m_axis_tvalid=0, frame_done=0.
  - m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0.
  - col=0, row=0; OR and SK invalid.
- Latency: input accepted at edge N gives m_axis_tvalid=1 in cycle N+1, if OR was empty or draining.
- Throughput: 1 pixel/cycle sustained when m_axis_tready is held high.
- Backpressure: when m_axis_tready drops with a stream in flight, at most one extra pixel is absorbed into SK. s_ready falls one cycle later.
- Recovery: the first output handshake after a stall frees SK. s_ready rises in the next cycle.
- Reset mid-operation: asserting rst on any edge discards OR and SK contents and returns the counters to 0. The next accepted pixel is tagged sof. No partial-frame flush is performed.
- Simultaneous input and output handshakes:
  - Occupancy is unchanged.
  - Ordering is preserved: SK→OR before the new pixel lands in SK.
  - When SK is empty, the new pixel goes directly into OR.

## Test plan
- OUT_W=4, OUT_H=2, s_valid and m_axis_tready both held 1, data 1..8 → tdata 1..8 on consecutive cycles after 1 cycle latency; tuser on pixel 1 only; tlast on pixels 4 and 8; frame_done one cycle after pixel 8's handshake.
- Backpressure: m_axis_tready=0 for 5 cycles mid-line with s_valid=1 → exactly 2 pixels held (OR+SK); s_ready=0 from the cycle after the stall begins; no loss or duplication; order is intact when m_axis_tready returns to 1.
- Random s_valid and m_axis_tready (50%) over 3 frames of 4×2 → output sequence equals input sequence; tags are correct per position; tdata, tuser and tlast are stable whenever tvalid & ~tready.
- Frame wrap: 2 consecutive frames with no gap → second frame's first pixel carries tuser=1; row and col return to 0; frame_done pulses exactly twice.
- Reset mid-line: assert rst after 3 pixels accepted with m_axis_tready=0 → the next cycle shows tvalid=0 and s_ready=1; the next accepted pixel emits with tuser=1.
- Reset values: hold rst for 2 cycles with random inputs → s_ready=1 and all other outputs 0 throughout.
